// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared constants and state encoding for the program loader
package prog_loader_pkg;
  localparam int ADDR_W = 10;
  localparam int INSTR_W = 18;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  typedef enum logic [3:0] {IDLE, CNT_HI, CNT_LO, B0, B1, B2, WRITE, CHK, ERR} state_t;
endpackage

// File: rtl/prog_loader.sv
// prog_loader: receives a serial program frame and writes it into program memory
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  input  logic [ADDR_W-1:0]  cpu_address,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic [3:0]         mem_we,
  output logic               cpu_reset,
  output logic               done,
  output logic               error
);
  state_t state;
  logic [ADDR_W-1:0] load_addr, last_addr;
  logic [7:0] sum, b1;
  logic [1:0] b0;
  logic take;
  assign rx_ready = state != WRITE;
  assign mem_address = state == IDLE ? cpu_address : load_addr;
  assign take = rx_valid && rx_ready;
  // frame parser; outputs are registered alongside the state they belong to
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      load_addr <= '0;
      last_addr <= '0;
      sum <= '0;
      b0 <= '0;
      b1 <= '0;
      mem_wdata <= '0;
      mem_we <= 4'h0;
      cpu_reset <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      done <= 1'b0;
      mem_we <= 4'h0;
      case (state)
        IDLE, ERR: if (take && rx_data == SYNC_BYTE) begin
          state <= CNT_HI;
          error <= 1'b0;
          sum <= '0;
          load_addr <= '0;
          cpu_reset <= 1'b1;
        end
        CNT_HI: if (take) begin
          last_addr[9:8] <= rx_data[1:0];
          sum <= sum + rx_data;
          state <= CNT_LO;
        end
        CNT_LO: if (take) begin
          last_addr[7:0] <= rx_data;
          sum <= sum + rx_data;
          state <= B0;
        end
        B0: if (take) begin
          b0 <= rx_data[1:0];
          sum <= sum + rx_data;
          state <= B1;
        end
        B1: if (take) begin
          b1 <= rx_data;
          sum <= sum + rx_data;
          state <= B2;
        end
        B2: if (take) begin
          mem_wdata <= {b0, b1, rx_data};
          mem_we <= 4'hF;
          sum <= sum + rx_data;
          state <= WRITE;
        end
        WRITE: begin
          load_addr <= load_addr + 1'b1;
          state <= load_addr == last_addr ? CHK : B0;
        end
        CHK: if (take) begin
          if (rx_data == sum) begin
            done <= 1'b1;
            cpu_reset <= 1'b0;
            state <= IDLE;
          end else begin
            error <= 1'b1;
            state <= ERR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
